lab1_sweep_checker: RTL and testbench

- Synthesizable stimulus/response stage for the 4-input Lab1 function implementations (gate-level, dataflow, UDP).
- Drives the shared input vector {A,B,C,D} through all 2^N codes and holds each code for a settle window.
- Samples the three implementation outputs once per code, builds the truth table, and flags any disagreement between implementations.
- Replaces the timed initial-block sweep with an on-chip, clocked sweep and checker.

---
 rtl/lab1_sweep_checker.sv | 182 ++++++++++++++++++
 tb/tb_lab1_sweep_checker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lab1_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : lab1_sweep_checker
// Description : Clocked stimulus/response stage for the Lab1 4-input function
//               implementations. Steps a shared input vector {A,B,C,D}
//               through every code, holds each code for a settle window,
//               samples the three implementation outputs once per code,
//               builds the truth table from f1 and counts the codes where
//               the three implementations disagree.
//
// Ports       : clk              rising-edge clock
//               rst              synchronous, active-high reset
//               start            one-cycle sweep request (ignored while busy)
//               abcd             drive vector; MSB = A, LSB = D
//               f1/f2/f3         gate-level / dataflow / UDP outputs
//               busy             sweep in progress
//               done             sweep complete, held until start or rst
//               pass             valid with done; 1 iff no mismatches
//               truth_table      bit i = f1 sampled while abcd == i
//               mismatch_cnt     vectors where f1, f2, f3 were not all equal
//               first_fail_vec   lowest mismatching vector
//               first_fail_valid first_fail_vec holds a real value
//
// Revision    : 1.0 - initial release
// ============================================================================
module lab1_sweep_checker #(
    parameter int N             = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [N-1:0]        abcd,
    input  logic                f1,
    input  logic                f2,
    input  logic                f3,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [(1<<N)-1:0]   truth_table,
    output logic [N:0]          mismatch_cnt,
    output logic [N-1:0]        first_fail_vec,
    output logic                first_fail_valid
);

    localparam logic [N-1:0] c_last_vec    = {N{1'b1}};
    localparam logic [7:0]   c_settle_last = 8'(SETTLE_CYCLES - 1);
    localparam logic [N-1:0] c_vec_one     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N:0]   c_cnt_one     = {{N{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    logic [N-1:0]         r_abcd;
    logic [7:0]           r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [(1<<N)-1:0]    r_tt;
    logic [N:0]           r_mm_cnt;
    logic [N-1:0]         r_ff_vec;
    logic                 r_ff_valid;

    state_t               w_state_nxt;
    logic [N-1:0]         w_abcd_nxt;
    logic [7:0]           w_cnt_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_pass_nxt;
    logic [(1<<N)-1:0]    w_tt_nxt;
    logic [N:0]           w_mm_cnt_nxt;
    logic [N-1:0]         w_ff_vec_nxt;
    logic                 w_ff_valid_nxt;
    logic                 w_mismatch;

    assign w_mismatch = !((f1 == f2) && (f2 == f3));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_abcd     <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_tt       <= '0;
            r_mm_cnt   <= '0;
            r_ff_vec   <= '0;
            r_ff_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_abcd     <= w_abcd_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_tt       <= w_tt_nxt;
            r_mm_cnt   <= w_mm_cnt_nxt;
            r_ff_vec   <= w_ff_vec_nxt;
            r_ff_valid <= w_ff_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_abcd_nxt     = r_abcd;
        w_cnt_nxt      = r_cnt;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_pass_nxt     = r_pass;
        w_tt_nxt       = r_tt;
        w_mm_cnt_nxt   = r_mm_cnt;
        w_ff_vec_nxt   = r_ff_vec;
        w_ff_valid_nxt = r_ff_valid;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt    = S_SETTLE;
                    w_abcd_nxt     = '0;
                    w_cnt_nxt      = '0;
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_pass_nxt     = 1'b0;
                    w_tt_nxt       = '0;
                    w_mm_cnt_nxt   = '0;
                    w_ff_vec_nxt   = '0;
                    w_ff_valid_nxt = 1'b0;
                end
            end

            S_SETTLE: begin
                w_cnt_nxt = r_cnt + 8'd1;
                if (r_cnt == c_settle_last) begin
                    w_state_nxt = S_SAMPLE;
                end
            end

            S_SAMPLE: begin
                w_tt_nxt[r_abcd] = f1;
                if (w_mismatch) begin
                    w_mm_cnt_nxt = r_mm_cnt + c_cnt_one;
                    if (!r_ff_valid) begin
                        w_ff_vec_nxt   = r_abcd;
                        w_ff_valid_nxt = 1'b1;
                    end
                end
                if (r_abcd == c_last_vec) begin
                    // pass must reflect the count including this last sample
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_mm_cnt_nxt == '0);
                end else begin
                    w_abcd_nxt  = r_abcd + c_vec_one;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SETTLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign abcd             = r_abcd;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign truth_table      = r_tt;
    assign mismatch_cnt     = r_mm_cnt;
    assign first_fail_vec   = r_ff_vec;
    assign first_fail_valid = r_ff_valid;

endmodule
`default_nettype wire

// File: tb/tb_lab1_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lab1_sweep_checker
// Description : Self-checking bench for lab1_sweep_checker. One instance uses
//               the default settle window with a parity function and
//               injectable faults on f2/f3; a second instance uses a one-cycle
//               settle window with f = A & B.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lab1_sweep_checker;

    typedef struct packed {
        logic [15:0] tt;
        logic [4:0]  mm;
        logic [3:0]  ffv;
        logic        ffvalid;
        logic        pass;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] m2 = '0;
    logic [15:0] m3 = '0;

    logic [3:0]  abcd, abcd1;
    logic        f1, f2, f3, g;
    logic        busy, done, pass, busy1, done1, pass1;
    logic [15:0] tt, tt1;
    logic [4:0]  mm, mm1;
    logic [3:0]  ffv, ffv1;
    logic        ffvalid, ffvalid1;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign f1 = ^abcd;
    assign f2 = (^abcd) ^ m2[abcd];
    assign f3 = (^abcd) ^ m3[abcd];
    assign g  = abcd1[3] & abcd1[2];

    lab1_sweep_checker #(.N(4), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abcd(abcd),
        .f1(f1), .f2(f2), .f3(f3),
        .busy(busy), .done(done), .pass(pass), .truth_table(tt),
        .mismatch_cnt(mm), .first_fail_vec(ffv), .first_fail_valid(ffvalid)
    );

    lab1_sweep_checker #(.N(4), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abcd(abcd1),
        .f1(g), .f2(g), .f3(g),
        .busy(busy1), .done(done1), .pass(pass1), .truth_table(tt1),
        .mismatch_cnt(mm1), .first_fail_vec(ffv1), .first_fail_valid(ffvalid1)
    );

    // Reference: f1 = parity, f2/f3 = parity with the given bits inverted.
    function automatic exp_t model(input logic [15:0] a2, input logic [15:0] a3);
        exp_t e;
        logic [3:0] v;
        logic p, g2, g3;
        e = '0;
        for (int i = 0; i < 16; i++) begin
            v  = 4'(i);
            p  = v[3] ^ v[2] ^ v[1] ^ v[0];
            g2 = p ^ a2[i];
            g3 = p ^ a3[i];
            e.tt[i] = p;
            if (!(p == g2 && g2 == g3)) begin
                if (!e.ffvalid) begin
                    e.ffv     = v;
                    e.ffvalid = 1'b1;
                end
                e.mm = e.mm + 5'd1;
            end
        end
        e.pass = (e.mm == 5'd0);
        return e;
    endfunction

    task automatic run_sweep(input string name, input logic [15:0] a2,
                             input logic [15:0] a3, input int repulse_at);
        exp_t e;
        m2 = a2;
        m3 = a3;
        sb.push_back(model(a2, a3));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_tests++;
        if ({busy, done, pass, abcd, tt, mm, ffvalid} !== {1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s start_clear: busy=%b done=%b pass=%b abcd=%0d tt=%h mm=%0d ffvalid=%b, required 1 0 0 0 0000 0 0",
                     name, busy, done, pass, abcd, tt, mm, ffvalid);
        end
        for (int m = 1; m <= 80; m++) begin
            if (m == repulse_at) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            if (m < 80) begin
                n_tests++;
                if ({abcd, busy, done} !== {4'(m / 5), 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL %s step%0d: abcd=%0d busy=%b done=%b, required abcd=%0d busy=1 done=0",
                             name, m, abcd, busy, done, m / 5);
                end
            end
        end
        n_tests++;
        if ({done, busy, abcd} !== {1'b1, 1'b0, 4'd15}) begin
            n_fail++;
            $display("FAIL %s done_at_80: done=%b busy=%b abcd=%0d, required 1 0 15", name, done, busy, abcd);
        end
        e = sb.pop_front();
        n_tests++;
        if ({tt, mm, ffv, ffvalid, pass} !== e) begin
            n_fail++;
            $display("FAIL %s results: tt=%h mm=%0d ffv=%0d ffvalid=%b pass=%b, required tt=%h mm=%0d ffv=%0d ffvalid=%b pass=%b",
                     name, tt, mm, ffv, ffvalid, pass, e.tt, e.mm, e.ffv, e.ffvalid, e.pass);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({done, busy, abcd, tt, mm, pass} !== {1'b1, 1'b0, 4'd15, e.tt, e.mm, e.pass}) begin
            n_fail++;
            $display("FAIL %s done_hold: done=%b busy=%b abcd=%0d tt=%h mm=%0d pass=%b", name, done, busy, abcd, tt, mm, pass);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_tests++;
        if ({abcd, busy, done, pass, tt, mm, ffv, ffvalid} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_state: abcd=%0d busy=%b done=%b pass=%b tt=%h mm=%0d ffv=%0d ffvalid=%b, required all 0",
                     abcd, busy, done, pass, tt, mm, ffv, ffvalid);
        end
    endtask

    task automatic test_parity;
        run_sweep("parity", 16'h0000, 16'h0000, -1);
        n_tests++;
        if (tt !== 16'h6996) begin
            n_fail++;
            $display("FAIL parity_tt: tt=%h, required 6996", tt);
        end
    endtask

    task automatic test_single_fault;
        run_sweep("fault_f3_at5", 16'h0000, 16'h0020, -1);
    endtask

    task automatic test_two_faults;
        run_sweep("fault_f2_at3_12", 16'h1008, 16'h0000, -1);
        run_sweep("fault_f2_at15", 16'h8000, 16'h0000, -1);
    endtask

    task automatic test_handshake;
        // start pulse sampled at edge 38 while abcd==7 must be ignored
        run_sweep("repulse_busy", 16'h0000, 16'h0000, 38);
        // launched from DONE: start_clear inside run_sweep covers the clear
        run_sweep("restart_from_done", 16'h0000, 16'h0020, -1);
    endtask

    task automatic test_reset_mid;
        m2 = '0;
        m3 = 16'h0001;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        n_tests++;
        if (abcd !== 4'd9 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_reset: abcd=%0d busy=%b, required 9 1", abcd, busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_tests++;
        if ({abcd, busy, done, pass, tt, mm, ffv, ffvalid} !== 33'd0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: abcd=%0d busy=%b done=%b pass=%b tt=%h mm=%0d ffv=%0d ffvalid=%b, required all 0",
                     abcd, busy, done, pass, tt, mm, ffv, ffvalid);
        end
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if ({abcd, busy, done} !== 6'd0) begin
            n_fail++;
            $display("FAIL mid_idle_quiet: abcd=%0d busy=%b done=%b, required 0 0 0", abcd, busy, done);
        end
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({abcd, busy, done} !== 6'd0) begin
            n_fail++;
            $display("FAIL rst_beats_start: abcd=%0d busy=%b done=%b, required 0 0 0", abcd, busy, done);
        end
        run_sweep("after_reset", 16'h0000, 16'h0000, -1);
    endtask

    task automatic test_settle1;
        exp_t e;
        sb.push_back('{tt: 16'hF000, mm: 5'd0, ffv: 4'd0, ffvalid: 1'b0, pass: 1'b1});
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int m = 1; m <= 32; m++) begin
            @(posedge clk);
            #1;
            if (m < 32) begin
                n_tests++;
                if ({abcd1, busy1, done1} !== {4'(m / 2), 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL settle1 step%0d: abcd=%0d busy=%b done=%b, required abcd=%0d busy=1 done=0",
                             m, abcd1, busy1, done1, m / 2);
                end
            end
        end
        e = sb.pop_front();
        n_tests++;
        if ({done1, busy1} !== 2'b10 || {tt1, mm1, ffv1, ffvalid1, pass1} !== e) begin
            n_fail++;
            $display("FAIL settle1 results: done=%b busy=%b tt=%h mm=%0d ffvalid=%b pass=%b, required done=1 busy=0 tt=%h mm=%0d ffvalid=%b pass=%b",
                     done1, busy1, tt1, mm1, ffvalid1, pass1, e.tt, e.mm, e.ffvalid, e.pass);
        end
    endtask

    initial begin
        test_reset();
        test_parity();
        test_single_fault();
        test_two_faults();
        test_handshake();
        test_reset_mid();
        test_settle1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
